// File: rtl/posit_decode_pipe_pkg.sv
// Shared posit definitions: width helpers, default derived widths and the decoded-posit record.
// Consumers of the optional counters build with POSIT_DEC_COUNT_EN; the package itself is unaffected.
package posit_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int fw_of(input int n, input int e);
    return n - e - 3;
  endfunction

  function automatic int sw_of(input int n, input int e);
    return log2(n) + e + 2;
  endfunction

  localparam int N_DEF  = 32;
  localparam int ES_DEF = 2;
  localparam int Bs     = log2(N_DEF);
  localparam int FW     = fw_of(N_DEF, ES_DEF);
  localparam int SW     = sw_of(N_DEF, ES_DEF);

  typedef struct packed {
    logic                 sign;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
    logic                 zero;
    logic                 inf;
  } posit_dec_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Operand/result handshake bundle for the posit decoder (start/ready in, done/ack out).
// Optional counters enabled by POSIT_DEC_COUNT_EN live on the top module, not here.
interface posit_decode_pipe_if import posit_pkg::*; #(
  parameter int N  = 32,
  parameter int es = 2
);
  localparam int fw = fw_of(N, es);
  localparam int sw = sw_of(N, es);

  logic [N-1:0]         in1;
  logic                 start;
  logic                 ready;
  logic                 sign;
  logic signed [sw-1:0] scale;
  logic [fw-1:0]        frac;
  logic                 zero;
  logic                 inf;
  logic                 done;
  logic                 ack;

  modport master (output in1, start, ack,
                  input  ready, sign, scale, frac, zero, inf, done);
  modport slave  (input  in1, start, ack,
                  output ready, sign, scale, frac, zero, inf, done);
endinterface

// File: rtl/posit_decode_pipe_lzd.sv
// Combinational leading-run detector: length of the run of vec[W-1] from the MSB, and its polarity.
// Used by posit_decode_pipe (optional counters via POSIT_DEC_COUNT_EN do not affect this block).
module posit_lzd #(
  parameter int W  = 31,
  parameter int CW = 5
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] run,
  output logic          pol
);

  logic stop;

  always_comb begin
    run  = '0;
    pol  = vec[W-1];
    stop = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!stop) begin
        if (vec[i] == vec[W-1]) run = run + CW'(1);
        else                    stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Three-stage posit unpacker with global stall backpressure (stall = done && !ack).
// Define POSIT_DEC_COUNT_EN to add the dec_count/special_count transfer counters.
module posit_decode_pipe import posit_pkg::*; #(
  parameter int N  = 32,
  parameter int es = 2
) (
  input  logic               aclk,
  input  logic               reset,
  posit_decode_pipe_if.slave bus
`ifdef POSIT_DEC_COUNT_EN
  ,
  output logic [31:0]        dec_count,
  output logic [15:0]        special_count
`endif
);

  localparam int bs = log2(N);
  localparam int fw = fw_of(N, es);
  localparam int sw = sw_of(N, es);
  localparam int kw = bs + 1;
  localparam int bw = N - 3;

  logic stall;
  assign stall     = bus.done && !bus.ack;
  assign bus.ready = !stall;

  logic         in_zero, in_inf;
  logic [N-2:0] in_body;
  assign in_zero = (bus.in1 == '0);
  assign in_inf  = bus.in1[N-1] && (bus.in1[N-2:0] == '0);
  assign in_body = bus.in1[N-1] ? (~bus.in1[N-2:0] + (N-1)'(1)) : bus.in1[N-2:0];

  logic         s1_v, s1_sign, s1_zero, s1_inf;
  logic [N-2:0] s1_body;

  always_ff @(posedge aclk) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_inf  <= 1'b0;
      s1_body <= '0;
    end else if (!stall) begin
      s1_v    <= bus.start;
      s1_sign <= bus.in1[N-1] && !in_inf;
      s1_zero <= in_zero;
      s1_inf  <= in_inf;
      s1_body <= in_body;
    end
  end

  logic [bs-1:0]        run;
  logic                 pol;
  logic [bs:0]          shamt;
  logic signed [kw-1:0] k_nx;
  logic [bw-1:0]        body_nx;

  posit_lzd #(.W(N - 1), .CW(bs)) u_lzd (
    .vec (s1_body),
    .run (run),
    .pol (pol)
  );

  // Shift past the run and its terminator; keep only the es+fw bits below them.
  assign shamt   = {1'b0, run} + (bs + 1)'(1);
  assign k_nx    = pol ? ({1'b0, run} - kw'(1)) : (-{1'b0, run});
  assign body_nx = bw'((s1_body << shamt) >> 2);

  logic                 s2_v, s2_sign, s2_zero, s2_inf;
  logic signed [kw-1:0] s2_k;
  logic [bw-1:0]        s2_body;

  always_ff @(posedge aclk) begin
    if (reset) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_inf  <= 1'b0;
      s2_k    <= '0;
      s2_body <= '0;
    end else if (!stall) begin
      s2_v    <= s1_v;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_inf  <= s1_inf;
      s2_k    <= (s1_zero || s1_inf) ? '0 : k_nx;
      s2_body <= (s1_zero || s1_inf) ? '0 : body_nx;
    end
  end

  logic signed [sw-1:0] scale_nx;
  logic [fw-1:0]        frac_nx;

  generate
    if (es > 0) begin : g_exp
      logic [es-1:0] expv;
      assign expv     = s2_body[bw-1 -: es];
      assign scale_nx = (sw'(s2_k) <<< es) + sw'(expv);
    end else begin : g_noexp
      assign scale_nx = sw'(s2_k);
    end
  endgenerate

  assign frac_nx = s2_body[fw-1:0];

  always_ff @(posedge aclk) begin
    if (reset) begin
      bus.done  <= 1'b0;
      bus.sign  <= 1'b0;
      bus.scale <= '0;
      bus.frac  <= '0;
      bus.zero  <= 1'b0;
      bus.inf   <= 1'b0;
    end else if (!stall) begin
      bus.done  <= s2_v;
      bus.sign  <= s2_sign;
      bus.scale <= scale_nx;
      bus.frac  <= frac_nx;
      bus.zero  <= s2_zero;
      bus.inf   <= s2_inf;
    end
  end

`ifdef POSIT_DEC_COUNT_EN
  always_ff @(posedge aclk) begin
    if (reset) begin
      dec_count     <= '0;
      special_count <= '0;
    end else if (bus.done && bus.ack) begin
      dec_count <= dec_count + 32'd1;
      if ((bus.zero || bus.inf) && (special_count != 16'hFFFF))
        special_count <= special_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Scoreboard bench for posit_decode_pipe (N=32, es=2); also checks the POSIT_DEC_COUNT_EN counters when defined.
module tb_posit_decode_pipe;
  import posit_pkg::*;

  localparam int N  = 32;
  localparam int ES = 2;

  logic aclk;
  logic reset;

  posit_decode_pipe_if #(.N(N), .es(ES)) bus ();

`ifdef POSIT_DEC_COUNT_EN
  logic [31:0] dec_count;
  logic [15:0] special_count;
`endif

  posit_decode_pipe #(.N(N), .es(ES)) dut (
    .aclk          (aclk),
    .reset         (reset),
    .bus           (bus)
`ifdef POSIT_DEC_COUNT_EN
    ,
    .dec_count     (dec_count),
    .special_count (special_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int         checks = 0;
  int         failures = 0;
  int         stall_cycles = 0;
  int         mdl_xfers = 0;
  int         mdl_specials = 0;
  bit         rnd_done = 0;
  posit_dec_t exp_q[$];

  // Reference: read the posit as a bit stream -- regime run, terminator, exponent, fraction.
  function automatic posit_dec_t ref_decode(input logic [31:0] x);
    posit_dec_t d;
    logic [31:0] a;
    bit          q[$];
    bit          first;
    int          r, k, e;
    logic [FW-1:0] f;
    d = '0;
    if (x == 32'h0) begin
      d.zero = 1'b1;
      return d;
    end
    if (x == 32'h8000_0000) begin
      d.inf = 1'b1;
      return d;
    end
    d.sign = x[31];
    a = x[31] ? -x : x;
    for (int i = 30; i >= 0; i--) q.push_back(a[i]);
    first = q[0];
    r = 0;
    while (q.size() > 0 && q[0] == first) begin
      void'(q.pop_front());
      r++;
    end
    if (q.size() > 0) void'(q.pop_front());
    k = first ? r - 1 : -r;
    e = 0;
    for (int i = 0; i < ES; i++) e = e * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
    f = '0;
    for (int i = 0; i < FW; i++) f = {f[FW-2:0], (q.size() > 0) ? q.pop_front() : 1'b0};
    d.scale = SW'(k * (1 << ES) + e);
    d.frac  = f;
    return d;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Present x and hold it until accepted; expected result enters the scoreboard on acceptance.
  task automatic applyStimulus(input logic [31:0] x);
    bit ok;
    ok = 0;
    @(negedge aclk);
    bus.in1   = x;
    bus.start = 1'b1;
    for (int w = 0; w < 200; w++) begin
      #2;
      if (bus.ready) begin
        ok = 1;
        break;
      end
      @(negedge aclk);
    end
    if (!ok) begin
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    exp_q.push_back(ref_decode(x));
    @(posedge aclk);
  endtask

  task automatic runDirected(input logic [31:0] x, input bit e_sign, input longint e_scale,
                             input longint e_frac, input bit e_zero, input bit e_inf);
    int lat;
    lat = 0;
    @(negedge aclk);
    bus.in1   = x;
    bus.start = 1'b1;
    #2;
    checkOutput("ready_idle", bus.ready, 1);
    exp_q.push_back(ref_decode(x));
    @(posedge aclk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge aclk);
      bus.start = 1'b0;
      #3;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    checkOutput("latency", lat, 3);
    checkOutput("sign", bus.sign, e_sign);
    checkOutput("scale", longint'(bus.scale), e_scale);
    checkOutput("frac", bus.frac, e_frac);
    checkOutput("zero", bus.zero, e_zero);
    checkOutput("inf", bus.inf, e_inf);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge aclk);
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  initial begin : monitor
    posit_dec_t cur, snap, e;
    bit prev_stall;
    prev_stall = 0;
    snap = '0;
    forever begin
      @(negedge aclk);
      #3;
      cur = '{sign: bus.sign, scale: bus.scale, frac: bus.frac, zero: bus.zero, inf: bus.inf};
      if (bus.done && !bus.ack) begin
        stall_cycles++;
        checkOutput("ready_on_stall", bus.ready, 0);
        if (prev_stall) begin
          checks++;
          if (cur !== snap) begin
            failures++;
            $display("[TB] FAIL hold_on_stall actual=%h expected=%h", cur, snap);
          end
        end
        snap = cur;
        prev_stall = 1;
      end else begin
        prev_stall = 0;
        checkOutput("ready_no_stall", bus.ready, 1);
      end
      if (bus.done && bus.ack && !reset) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL scoreboard_extra actual=%h expected=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("[TB] FAIL scoreboard actual s=%0b sc=%0d f=%0h z=%0b i=%0b expected s=%0b sc=%0d f=%0h z=%0b i=%0b",
                     cur.sign, $signed(cur.scale), cur.frac, cur.zero, cur.inf,
                     e.sign, $signed(e.scale), e.frac, e.zero, e.inf);
          end
          mdl_xfers++;
          if ((e.zero || e.inf) && mdl_specials != 16'hFFFF) mdl_specials++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int s0;
    logic [31:0] x;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.ack   = 1'b1;
    bus.in1   = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #3;
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_sign", bus.sign, 0);
    checkOutput("rst_scale", longint'(bus.scale), 0);
    checkOutput("rst_frac", bus.frac, 0);
    checkOutput("rst_zero", bus.zero, 0);
    checkOutput("rst_inf", bus.inf, 0);
`ifdef POSIT_DEC_COUNT_EN
    checkOutput("rst_dec_count", dec_count, 0);
    checkOutput("rst_special_count", special_count, 0);
`endif
    reset = 1'b0;
    @(negedge aclk);
    #3;
    checkOutput("rst_ready", bus.ready, 1);

    runDirected(32'h4000_0000, 0, 0, 0, 0, 0);
    runDirected(32'h4800_0000, 0, 1, 0, 0, 0);
    runDirected(32'hC000_0000, 1, 0, 0, 0, 0);
    runDirected(32'h7FFF_FFFF, 0, 120, 0, 0, 0);
    runDirected(32'h0000_0001, 0, -120, 0, 0, 0);
    runDirected(32'h0000_0000, 0, 0, 0, 1, 0);
    runDirected(32'h8000_0000, 0, 0, 0, 0, 1);
    runDirected(32'h4C00_0000, 0, 1, 32'h0400_0000, 0, 0);

    $display("[TB] stall stream");
    s0 = stall_cycles;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus($urandom);
        @(negedge aclk);
        bus.start = 1'b0;
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          @(negedge aclk);
          bus.ack = !(c >= 5 && c <= 8);
        end
      end
    join
    waitDrain();
    checkOutput("stall_cycles", stall_cycles - s0, 4);

    $display("[TB] random stream");
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          case ($urandom_range(0, 9))
            0: x = 32'h0;
            1: x = 32'h8000_0000;
            2: x = 32'h7FFF_FFFF;
            3: x = 32'h8000_0001;
            4: x = $urandom >> $urandom_range(0, 31);
            default: x = $urandom;
          endcase
          applyStimulus(x);
          if ($urandom_range(0, 3) == 0) begin
            @(negedge aclk);
            bus.start = 1'b0;
          end
        end
        @(negedge aclk);
        bus.start = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(negedge aclk);
          bus.ack = ($urandom_range(0, 9) < 7);
        end
      end
    join
    @(negedge aclk);
    bus.ack = 1'b1;
    waitDrain();
`ifdef POSIT_DEC_COUNT_EN
    #3;
    checkOutput("dec_count", dec_count, mdl_xfers);
    checkOutput("special_count", special_count, mdl_specials);
`endif

    $display("[TB] reset with operands in flight");
    @(negedge aclk);
    bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus($urandom);
    @(negedge aclk);
    bus.start = 1'b1;
    bus.in1   = 32'h4000_0000;
    reset     = 1'b1;
    @(posedge aclk);
    exp_q.delete();
    mdl_xfers = 0;
    mdl_specials = 0;
    @(negedge aclk);
    bus.start = 1'b0;
    #3;
    checkOutput("flush_done", bus.done, 0);
    checkOutput("flush_ready", bus.ready, 1);
`ifdef POSIT_DEC_COUNT_EN
    checkOutput("flush_dec_count", dec_count, 0);
    checkOutput("flush_special_count", special_count, 0);
`endif
    reset   = 1'b0;
    bus.ack = 1'b1;
    @(negedge aclk);
    #3;
    checkOutput("flush_no_emit", bus.done, 0);
    runDirected(32'h4800_0000, 0, 1, 0, 0, 0);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
- Pipelined posit unpacker: accepts one N-bit posit per handshake and emits sign, combined scale (regime·2^es + exponent), left-aligned fraction, and zero/inf flags.
- It performs the inverse of the pack/round stage that ends posit_mult_4, and feeds decoded operands into the mult/add datapaths and the result checkers.
- Three-stage pipeline with full backpressure.

Parameters:
- N, 32, posit width in bits (≥8)
- es, 2, exponent field width (0..4)
- Bs, log2(N), derived, not overridden; regime count width
- FW, N-es-3, derived; fraction output width
- SW, Bs+es+2, derived; signed scale width

Ports:
- aclk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in1  in  N  posit operand, sampled when start && ready
- start  in  1  input valid
- ready  out  1  input accept; low while the pipeline is stalled
- sign  out  1  operand sign
- scale  out  SW  signed power-of-two, k·2^es + exp
- frac  out  FW  fraction without hidden bit, MSB-aligned, zero-padded
- zero  out  1  operand was 0
- inf  out  1  operand was NaR (1 followed by N-1 zeros)
- done  out  1  output valid
- ack  in  1  output accept; transfer occurs when done && ack

Behaviour:
- Reset, on the next aclk edge with reset high:
  - done=0, sign=0, scale=0, frac=0, zero=0, inf=0.
  - All stage valids cleared; ready=1 in the cycle after reset.
  - A reset mid-operation discards every in-flight operand; nothing is emitted.
- Pipeline stages:
  - S1 captures in1. It flags zero (all zeros) and inf (MSB 1, rest 0). If MSB=1, the remaining bits are two's-complemented (absolute value).
  - S2 counts the leading run of bit N-2 across bits N-2..0 (run length r, 1..N-1). k = r-1 if the run is ones, else -r. The body is shifted left by r+1, so the terminator is dropped.
  - S3 takes exp from the top es bits of the shifted body (missing bits read as 0). frac is the next FW bits. scale = k·2^es + exp, sign-extended to SW.
- Latency: exactly 3 cycles from an accepted start to done with no stall. Throughput: 1 operand/cycle.
- Stall rule: stall = done && !ack.
  - While stalled, every stage holds and ready=0. ready is combinational from done and ack.
  - Outputs stay stable while done=1 and ack=0.
- Bubbles: empty stages advance even when later stages are full and not stalled. No reordering.
- zero or inf: sign=0, scale=0, frac=0. Exactly one of zero/inf is set; otherwise both are 0.
- Maximal run (no terminator): k = N-2 for ones, -(N-1) for zeros; exp=0, frac=0.
- start without ready: the operand is not taken, and the source must hold it. A start during reset is ignored.

Optional Feature:
- Macro POSIT_DEC_COUNT_EN.
- When defined:
  - Adds output port dec_count (32 bits). It increments on every done && ack transfer and wraps at 2^32-1 → 0.
  - Adds output port special_count (16 bits). It increments on transfers with zero or inf set and saturates at 0xFFFF.
  - Both counters clear on reset.
- When not defined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package posit_pkg holds:
  - the log2 constant function;
  - the derived width constants FW, SW, Bs;
  - a decoded-posit struct (sign, scale, frac, zero, inf) reused by posit_mult_4's successors and checkers.
- One natural sub-module: posit_lzd, a parameterised leading-run detector (N-1 bits in, run length and polarity out, combinational). It is instantiated in S2.

Test Plan (N=32, es=2, ack=1 unless stated):
- in1=0x40000000 → after 3 cycles done=1, sign=0, scale=0, frac=0, zero=0, inf=0.
- in1=0x48000000 → scale=1, frac=0. Then in1=0xC0000000 → sign=1, scale=0.
- in1=0x7FFFFFFF → scale=120, frac=0. in1=0x00000001 → scale=-120.
- in1=0x00000000 → zero=1, scale=0. in1=0x80000000 → inf=1, sign=0.
- Back-to-back stream of 8 operands with ack low for cycles 5-8:
  - ready drops the same cycle done=1 and ack=0, and outputs hold.
  - All 8 results emerge in order, none lost or duplicated.
- Reset asserted with 3 operands in flight → done=0 next cycle, no results emitted. The next operand decodes correctly with latency 3. With POSIT_DEC_COUNT_EN, counters read 0 after reset.
